// File: rtl/mole_game_ctrl.sv
// Whack-a-mole game controller: game FSM, LFSR mole spawner, per-hole mole
// lifetimes, game timer and saturating score with optional miss penalty.
module mole_game_ctrl #(
  parameter int unsigned HOLES        = 9,
  parameter int unsigned SCORE_W      = 8,
  parameter int unsigned TICK_DIV     = 100_000_000,
  parameter int unsigned SPAWN_TICKS  = 8,
  parameter int unsigned LIFE_TICKS   = 12,
  parameter int unsigned GAME_TICKS   = 300,
  parameter int unsigned MAX_MOLES    = 3,
  parameter bit          MISS_PENALTY = 1'b0,
  parameter logic [15:0] SEED         = 16'hACE1,
  localparam int unsigned POS_W       = $clog2(HOLES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_game,
  input  logic               hit_valid,
  input  logic [POS_W-1:0]   hit_pos,
  output logic [HOLES-1:0]   map,
  output logic [SCORE_W-1:0] cur_score,
  output logic [2:0]         cur_state,
  output logic [15:0]        time_left,
  output logic               en_music,
  output logic               hit_ok,
  output logic               miss
);

  localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SPAWN_W = (SPAWN_TICKS > 1) ? $clog2(SPAWN_TICKS) : 1;
  localparam int unsigned LIFE_W  = $clog2(LIFE_TICKS + 1);
  // Galois feedback mask for taps 16,14,13,11 (right-shifting form).
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StPlay = 3'd1,
    StOver = 3'd2
  } state_e;

  state_e               state_q, state_d;
  logic [HOLES-1:0]     map_q, map_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [15:0]          time_q, time_d;
  logic                 music_q, music_d;
  logic                 hit_ok_q, hit_ok_d;
  logic                 miss_q, miss_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [SPAWN_W-1:0]   spawn_cnt_q, spawn_cnt_d;
  logic [LIFE_W-1:0]    life_q [HOLES];
  logic [LIFE_W-1:0]    life_d [HOLES];

  logic                 tick;
  logic                 hit_in_range;
  logic [POS_W-1:0]     spawn_pos;
  int unsigned          mole_cnt;

  assign tick         = (state_q == StPlay) && (presc_q == PRESC_W'(TICK_DIV - 1));
  assign hit_in_range = (32'(hit_pos) < HOLES);

  // Spawn candidate and current mole count, both taken from the pre-cycle state.
  always_comb begin
    spawn_pos = POS_W'(lfsr_q[7:0] % 8'(HOLES));
    mole_cnt  = 0;
    for (int i = 0; i < int'(HOLES); i++) begin
      if (map_q[i]) mole_cnt++;
    end
  end

  // Next-state logic: FSM, timer, spawn/expiry, hit scoring.
  always_comb begin
    state_d     = state_q;
    map_d       = map_q;
    score_d     = score_q;
    time_d      = time_q;
    hit_ok_d    = 1'b0;
    miss_d      = 1'b0;
    presc_d     = presc_q;
    spawn_cnt_d = spawn_cnt_q;
    life_d      = life_q;
    lfsr_d      = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

    unique case (state_q)
      StIdle, StOver: begin
        // A simultaneous hit is ignored: start only.
        if (start_game) begin
          state_d     = StPlay;
          map_d       = '0;
          score_d     = '0;
          time_d      = 16'(GAME_TICKS);
          presc_d     = '0;
          spawn_cnt_d = '0;
          for (int i = 0; i < int'(HOLES); i++) life_d[i] = '0;
        end
      end
      StPlay: begin
        if (tick) begin
          presc_d = '0;
          time_d  = time_q - 16'd1;
          for (int i = 0; i < int'(HOLES); i++) begin
            if (life_q[i] != '0) begin
              life_d[i] = life_q[i] - 1'b1;
              if (life_q[i] == LIFE_W'(1)) map_d[i] = 1'b0;
            end
          end
          if (spawn_cnt_q == SPAWN_W'(SPAWN_TICKS - 1)) begin
            spawn_cnt_d = '0;
            if (!map_q[spawn_pos] && (mole_cnt < MAX_MOLES)) begin
              map_d[spawn_pos]  = 1'b1;
              life_d[spawn_pos] = LIFE_W'(LIFE_TICKS);
            end
          end else begin
            spawn_cnt_d = spawn_cnt_q + 1'b1;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end

        // Hit is judged on the pre-cycle map; it overrides a same-cycle expiry.
        if (hit_valid && hit_in_range) begin
          if (map_q[hit_pos]) begin
            map_d[hit_pos]  = 1'b0;
            life_d[hit_pos] = '0;
            hit_ok_d        = 1'b1;
            if (score_q != '1) score_d = score_q + 1'b1;
          end else begin
            miss_d = 1'b1;
            if (MISS_PENALTY && (score_q != '0)) score_d = score_q - 1'b1;
          end
        end

        // Last tick: score is kept, board is wiped.
        if (tick && (time_q == 16'd1)) begin
          state_d = StOver;
          map_d   = '0;
          for (int i = 0; i < int'(HOLES); i++) life_d[i] = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    music_d = (state_d == StPlay);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      map_q       <= '0;
      score_q     <= '0;
      time_q      <= '0;
      music_q     <= 1'b0;
      hit_ok_q    <= 1'b0;
      miss_q      <= 1'b0;
      lfsr_q      <= SEED;
      presc_q     <= '0;
      spawn_cnt_q <= '0;
      for (int i = 0; i < int'(HOLES); i++) life_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      map_q       <= map_d;
      score_q     <= score_d;
      time_q      <= time_d;
      music_q     <= music_d;
      hit_ok_q    <= hit_ok_d;
      miss_q      <= miss_d;
      lfsr_q      <= lfsr_d;
      presc_q     <= presc_d;
      spawn_cnt_q <= spawn_cnt_d;
      for (int i = 0; i < int'(HOLES); i++) life_q[i] <= life_d[i];
    end
  end

  assign map       = map_q;
  assign cur_score = score_q;
  assign cur_state = state_q;
  assign time_left = time_q;
  assign en_music  = music_q;
  assign hit_ok    = hit_ok_q;
  assign miss      = miss_q;

endmodule
